// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm -> pre-trigger fill -> trigger -> post-trigger fill -> done.
// Optional trigger timestamp counter is enabled by defining TRACE_CAPTURE_TIMESTAMP_EN.
module trace_capture_ctrl #(
  parameter int TRACE_BUF_ADDR_WIDTH = 15,
  parameter int TS_WIDTH             = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            sample_tick,
  input  logic                            arm,
  input  logic                            abort,
  input  logic                            trig_in,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] pre_len,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] post_len,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] buf_wr_addr,
  output logic                            cap_tick,
  output logic [1:0]                      state,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trig_addr,
  output logic                            pre_short,
  output logic                            done,
  output logic [TS_WIDTH-1:0]             trig_ts
);

  localparam int AW = TRACE_BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] PRE_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   POST_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_q;
  logic          trig_q;
  logic          cap_tick_q;
  logic          pre_short_q;
  logic [AW-1:0] trig_addr_q;
  logic [AW-1:0] pre_cnt_q;
  // One extra bit so the post counter never wraps at the maximum post_len.
  logic [AW:0]   post_cnt_q;

  logic          trig_edge_d;
  logic          pre_under_d;
  logic          post_last_d;

  assign trig_edge_d = trig_in & ~trig_q;
  assign pre_under_d = (pre_cnt_q < pre_len);
  assign post_last_d = ((post_cnt_q + POST_ONE) == {1'b0, post_len});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      cap_tick_q  <= 1'b0;
      pre_short_q <= 1'b0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
    end else begin
      trig_q     <= trig_in;
      cap_tick_q <= sample_tick && ((state_q == PRE) || (state_q == POST));
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (arm) begin
              state_q     <= PRE;
              pre_cnt_q   <= '0;
              post_cnt_q  <= '0;
              pre_short_q <= 1'b0;
              trig_addr_q <= '0;
            end
          end
          PRE: begin
            if (sample_tick && pre_under_d)
              pre_cnt_q <= pre_cnt_q + PRE_ONE;
            // pre_short judges the count before any tick landing on the trigger cycle.
            if (trig_edge_d) begin
              trig_addr_q <= buf_wr_addr;
              pre_short_q <= pre_under_d;
              state_q     <= (post_len == '0) ? DONE : POST;
            end
          end
          POST: begin
            if (sample_tick) begin
              post_cnt_q <= post_cnt_q + POST_ONE;
              if (post_last_d)
                state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q;
  logic [TS_WIDTH-1:0] trig_ts_q;
  logic                trig_take_d;

  assign trig_take_d = trig_edge_d && (state_q == PRE) && !abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
      if (trig_take_d)
        trig_ts_q <= ts_cnt_q;
    end
  end

  assign trig_ts = trig_ts_q;
`else
  assign trig_ts = '0;
`endif

  assign cap_tick  = cap_tick_q;
  assign state     = state_q;
  assign trig_addr = trig_addr_q;
  assign pre_short = pre_short_q;
  assign done      = (state_q == DONE);

endmodule
